// File: rtl/xs3_to_bin_acc.sv
// Excess-3 digit stream to binary accumulator.
// Collects up to NDIGITS excess-3 digits (MSD first) into a binary word via
// acc*10 + d. The result is presented on a valid/ready port with error flags.
module xs3_to_bin_acc #(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned OUT_W   = 14,
    parameter int unsigned CNT_W   = $clog2(NDIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_xs3,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bin,
    output logic [CNT_W-1:0] out_digits,
    output logic [1:0]       out_err
);

    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err0_q, err0_d;
    logic [OUT_W-1:0]   out_bin_q, out_bin_d;
    logic [CNT_W-1:0]   out_digits_q, out_digits_d;
    logic [1:0]         out_err_q, out_err_d;

    logic               accept;
    logic               out_accept;
    logic               dig_legal;
    logic [4:0]         dig_val;
    logic [OUT_W-1:0]   acc_step;
    logic [CNT_W-1:0]   cnt_step;
    logic               err0_step;
    logic               frame_end;

    assign accept     = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    // Digit decode and multiply-by-10-and-add step.
    always_comb begin
        dig_legal = (in_xs3 >= 5'd3) && (in_xs3 <= 5'd12);
        dig_val   = dig_legal ? (in_xs3 - 5'd3) : 5'd0;
        acc_step  = {acc_q[OUT_W-4:0], 3'b000} + {acc_q[OUT_W-2:0], 1'b0} + OUT_W'(dig_val);
        cnt_step  = cnt_q + CNT_W'(1);
        err0_step = err0_q | ~dig_legal;
        frame_end = accept && (in_last || (cnt_step == CNT_W'(NDIGITS)));
    end

    // State register plus datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StAcc;
            acc_q        <= '0;
            cnt_q        <= '0;
            err0_q       <= 1'b0;
            out_bin_q    <= '0;
            out_digits_q <= '0;
            out_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            err0_q       <= err0_d;
            out_bin_q    <= out_bin_d;
            out_digits_q <= out_digits_d;
            out_err_q    <= out_err_d;
        end
    end

    // Next-state logic: ACC until a frame ends, HOLD until the result is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc:   if (frame_end)  state_d = StHold;
            StHold:  if (out_accept) state_d = StAcc;
            default: state_d = StAcc;
        endcase
    end

    // Datapath next values: accumulate on accept, snapshot on frame end, clear on hand-off.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        err0_d       = err0_q;
        out_bin_d    = out_bin_q;
        out_digits_d = out_digits_q;
        out_err_d    = out_err_q;
        if (accept) begin
            acc_d  = acc_step;
            cnt_d  = cnt_step;
            err0_d = err0_step;
        end
        if (frame_end) begin
            out_bin_d    = acc_step;
            out_digits_d = cnt_step;
            // Truncation only when the digit limit, not in_last, closed the frame.
            out_err_d    = {~in_last, err0_step};
        end
        if (out_accept) begin
            acc_d  = '0;
            cnt_d  = '0;
            err0_d = 1'b0;
        end
    end

    // Handshake outputs decoded from state; in_ready held low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAcc:   in_ready  = ~rst;
            StHold:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_bin    = out_bin_q;
    assign out_digits = out_digits_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_xs3_to_bin_acc.sv
// Self-checking bench for xs3_to_bin_acc: directed scenarios plus a randomized
// digit stream compared against a decimal reference model.
module tb_xs3_to_bin_acc;

    localparam int NDIGITS = 4;
    localparam int OUT_W   = 14;
    localparam int CNT_W   = $clog2(NDIGITS + 1);
    localparam int RES_W   = OUT_W + CNT_W + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_xs3 = 5'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_bin;
    logic [CNT_W-1:0] out_digits;
    logic [1:0]       out_err;

    logic or_dir = 1'b1;
    logic rand_mode = 1'b0;
    logic rr = 1'b1;
    assign out_ready = rand_mode ? rr : or_dir;

    int checks = 0;
    int errors = 0;

    logic [RES_W-1:0] col_q[$];
    logic [RES_W-1:0] exp_q[$];

    xs3_to_bin_acc #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_xs3    (in_xs3),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_digits(out_digits),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) rr = ($urandom_range(0, 2) != 0);

    // Record every completed output handshake.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) col_q.push_back({out_bin, out_digits, out_err});
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // Offer one digit from a falling edge and hold it until it is accepted.
    task automatic send(input logic [4:0] c, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_xs3   = c;
        in_last  = l;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        checks++; if (out_bin !== '0) begin errors++; $display("FAIL rst_bin got %0d want 0", out_bin); end
        checks++; if (out_digits !== '0) begin errors++; $display("FAIL rst_digits got %0d want 0", out_digits); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", out_err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_1234();
        or_dir = 1'b1;
        send(5'd4, 1'b0); send(5'd5, 1'b0); send(5'd6, 1'b0); send(5'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1234_valid got %0b want 1", out_valid); end
        checks++; if (out_bin !== 14'd1234) begin errors++; $display("FAIL t1234_bin got %0d want 1234", out_bin); end
        checks++; if (out_digits !== 3'd4) begin errors++; $display("FAIL t1234_digits got %0d want 4", out_digits); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL t1234_err got %b want 00", out_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t1234_hold_ready got %0b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1234_one_cycle got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1234_ready_back got %0b want 1", in_ready); end
    endtask

    task automatic test_single();
        send(5'd12, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_bin !== 14'd9) begin errors++; $display("FAIL single_bin got %0d want 9", out_bin); end
        checks++; if (out_digits !== 3'd1) begin errors++; $display("FAIL single_digits got %0d want 1", out_digits); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL single_err got %b want 00", out_err); end
    endtask

    task automatic test_illegal();
        send(5'd4, 1'b0); send(5'd15, 1'b0); send(5'd5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_bin !== 14'd102) begin errors++; $display("FAIL illegal_bin got %0d want 102", out_bin); end
        checks++; if (out_digits !== 3'd3) begin errors++; $display("FAIL illegal_digits got %0d want 3", out_digits); end
        checks++; if (out_err !== 2'b01) begin errors++; $display("FAIL illegal_err got %b want 01", out_err); end
    endtask

    task automatic test_truncate();
        send(5'd3, 1'b0); send(5'd3, 1'b0); send(5'd3, 1'b0); send(5'd4, 1'b0);
        @(negedge clk);
        // Next digit is offered while the result is still held.
        in_valid = 1'b1; in_xs3 = 5'd8; in_last = 1'b1;
        checks++; if (out_bin !== 14'd1) begin errors++; $display("FAIL trunc_bin got %0d want 1", out_bin); end
        checks++; if (out_digits !== 3'd4) begin errors++; $display("FAIL trunc_digits got %0d want 4", out_digits); end
        checks++; if (out_err !== 2'b10) begin errors++; $display("FAIL trunc_err got %b want 10", out_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trunc_stall got %0b want 0", in_ready); end
        send(5'd8, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_bin !== 14'd5) begin errors++; $display("FAIL trunc_next_bin got %0d want 5", out_bin); end
        checks++; if (out_digits !== 3'd1) begin errors++; $display("FAIL trunc_next_digits got %0d want 1", out_digits); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL trunc_next_err got %b want 00", out_err); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        or_dir = 1'b0;
        send(5'd9, 1'b0); send(5'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_xs3 = 5'd3; in_last = 1'b1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, out_valid); end
            checks++; if (out_bin !== 14'd66) begin errors++; $display("FAIL bp_bin[%0d] got %0d want 66", i, out_bin); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b want 0", i, in_ready); end
        end
        or_dir = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        // The stalled digit forms a one-digit frame of value 0.
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled_valid got %0b want 1", out_valid); end
        checks++; if (out_bin !== 14'd0) begin errors++; $display("FAIL bp_stalled_bin got %0d want 0", out_bin); end
        checks++; if (out_digits !== 3'd1) begin errors++; $display("FAIL bp_stalled_digits got %0d want 1", out_digits); end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        // Reset while a result is held.
        or_dir = 1'b0;
        send(5'd12, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_bin !== 14'd9) begin errors++; $display("FAIL rhold_pre_bin got %0d want 9", out_bin); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rhold_valid got %0b want 0", out_valid); end
        checks++; if (out_bin !== '0) begin errors++; $display("FAIL rhold_bin got %0d want 0", out_bin); end
        checks++; if (out_digits !== '0) begin errors++; $display("FAIL rhold_digits got %0d want 0", out_digits); end
        @(negedge clk);
        rst = 1'b0;
        or_dir = 1'b1;
        // Reset after two accepted digits.
        send(5'd5, 1'b0); send(5'd6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL rmid_err got %b want 00", out_err); end
        @(negedge clk);
        rst = 1'b0;
        send(5'd5, 1'b0); send(5'd6, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_bin !== 14'd23) begin errors++; $display("FAIL rmid_new_bin got %0d want 23", out_bin); end
        checks++; if (out_digits !== 3'd2) begin errors++; $display("FAIL rmid_new_digits got %0d want 2", out_digits); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL rmid_new_err got %b want 00", out_err); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        col_q.delete();
        exp_q.delete();
        rand_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int          len;
            logic        lst;
            int unsigned val;
            logic        bad;
            len = $urandom_range(1, NDIGITS);
            lst = (len < NDIGITS) ? 1'b1 : 1'($urandom_range(0, 1));
            val = 0;
            bad = 1'b0;
            for (int k = 0; k < len; k++) begin
                int unsigned c;
                if ($urandom_range(0, 9) < 8) c = $urandom_range(3, 12);
                else c = $urandom_range(0, 31);
                // Decimal reference: illegal codes count as digit 0 and flag the frame.
                if (c >= 3 && c <= 12) val = val * 10 + (c - 3);
                else begin val = val * 10; bad = 1'b1; end
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_xs3   = 5'($urandom);
                end
                send(5'(c), (k == len - 1) ? lst : 1'b0);
            end
            exp_q.push_back({OUT_W'(val), CNT_W'(len), (len == NDIGITS) && !lst, bad});
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (col_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        rand_mode = 1'b0;
        checks++;
        if (col_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", col_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < col_q.size(); i++) begin
            checks++;
            if (col_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_frame[%0d] got bin=%0d dig=%0d err=%b want bin=%0d dig=%0d err=%b",
                         i, col_q[i][RES_W-1:CNT_W+2], col_q[i][CNT_W+1:2], col_q[i][1:0],
                         exp_q[i][RES_W-1:CNT_W+2], exp_q[i][CNT_W+1:2], exp_q[i][1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_single();
        test_illegal();
        test_truncate();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xs3_to_bin_acc.md
# xs3_to_bin_acc

Downstream consumer of the 5-bit excess-3 digit stream produced by the binary-to-excess-3 stage. Accepts one excess-3 decimal digit per handshake, most significant first, and builds a binary value by multiply-by-10-and-add. Emits one binary word per frame through a valid/ready output with error flags. A frame ends on a digit marked last or on the NDIGITS-th digit.

## Interface
- NDIGITS, 4: maximum digits per frame (1..7).
- OUT_W, 14: result width; must satisfy 2^OUT_W > 10^NDIGITS - 1 (14 for 4 digits).
- CNT_W, $clog2(NDIGITS+1): digit-count width.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_xs3/in_last valid.
- in_ready  output  1  block can accept a digit.
- in_xs3  input  5  excess-3 code; legal decimal codes 3..12.
- in_last  input  1  current digit is the final digit of the frame.
- out_valid  output  1  result word valid.
- out_ready  input  1  downstream accepts result.
- out_bin  output  OUT_W  binary value of the frame.
- out_digits  output  CNT_W  number of digits accepted in the frame (1..NDIGITS).
- out_err  output  2  bit0: at least one illegal code in the frame; bit1: frame truncated (NDIGITS reached without in_last).

## Operation
- Two states: ACC (collecting digits) and HOLD (result presented).
- Reset: state ACC, accumulator 0, count 0, error flags 0; out_valid=0, out_bin=0, out_digits=0, out_err=0; in_ready=1 after reset deasserts.
- in_ready = 1 in ACC, 0 in HOLD. out_valid = 1 in HOLD only.
- Digit accept: in_valid && in_ready at a rising edge.
- Digit value d = in_xs3 - 3 when 3 <= in_xs3 <= 12. Otherwise d = 0, sticky err bit0 set for the frame, and the digit still counts toward out_digits.
- Accumulate: acc <= acc*10 + d, implemented as (acc<<3)+(acc<<1)+d at OUT_W bits. No overflow is possible within NDIGITS digits.
- Count increments on each accept.
- Frame end: accept with in_last=1, or accept of digit number NDIGITS.
  - On frame end, load out_bin, out_digits and out_err from the next-state values, and go to HOLD.
  - err bit1 = 1 only when the frame ended on count without in_last.
- In HOLD, out_bin, out_digits and out_err stay stable until out_valid && out_ready.
- Output accept: go to ACC and clear acc, count and sticky flags. out_bin, out_digits and out_err keep their last values, which are don't-care while out_valid=0.
- An input offered while in HOLD is not consumed; the sender holds it until in_ready returns.

## Timing
- Digit accepted at edge k updates acc by edge k; no bubbles between consecutive accepts in ACC.
- Latency: final digit accepted at edge N drives out_valid=1 in the cycle after edge N.
- Output handshake at edge M: in_ready=1 from the cycle after M. There is no same-cycle bypass, so the minimum gap between frames is one HOLD cycle.
- Reset asserted at any time, including mid-frame or in HOLD, immediately discards the partial frame or the pending result and forces reset values asynchronously.
- in_xs3 is sampled only on an accept; its value is ignored otherwise.

## Test plan
- Codes 4,5,6,7 with last on 7, out_ready=1 → out_bin=1234, out_digits=4, out_err=00, out_valid for 1 cycle, one cycle after the last accept.
- Single code 12 with last → out_bin=9, out_digits=1, out_err=00.
- Codes 4,15,5 with last on 5 → out_bin=102, out_digits=3, out_err=01.
- Codes 3,3,3,4,8 continuous, no last → first result out_bin=1, out_digits=4, out_err=10. Code 8 is stalled during HOLD, then accepted as the first digit of the next frame.
- Backpressure: frame 9,9 with last, out_ready=0 for 5 cycles → out_bin=66 stable, in_ready=0 and a presented digit not consumed. When out_ready rises, handshake occurs and in_ready=1 next cycle.
- Assert rst for 1 cycle after 2 accepted digits → all outputs 0 immediately; new frame 5,6 with last → out_bin=23, out_err=00.
